// File: rtl/acq_uart_pkg.sv
// rtl/acq_uart_pkg.sv - shared FSM type and frame constants for the acquisition UART framer
package acq_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_HI,
    ST_RD_SETTLE,
    ST_CAPTURE,
    ST_SEND,
    ST_DONE
  } state_t;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
  localparam int         FRAME_LEN      = 8;
  localparam int         IDX_W          = $clog2(FRAME_LEN);

  typedef logic [IDX_W-1:0] idx_t;

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 byte serializer with a one-cycle done pulse at the end of the stop bit
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 234
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]        BIT_LAST  = 4'd9;

  logic [BAUD_W-1:0] baud_cnt;
  logic [3:0]        bit_cnt;
  logic [8:0]        shreg;
  logic              active;
  logic              bit_end;

  assign bit_end = active && (baud_cnt == BAUD_LAST);
  assign done    = bit_end && (bit_cnt == BIT_LAST);
  assign busy    = active;

  // A start seen in the final stop-bit cycle chains the next byte with no idle gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active   <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '1;
      tx       <= 1'b1;
    end else if (start && (!active || done)) begin
      active   <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= {1'b1, data};
      tx       <= 1'b0;
    end else if (bit_end) begin
      baud_cnt <= '0;
      if (bit_cnt == BIT_LAST) begin
        active <= 1'b0;
        tx     <= 1'b1;
      end else begin
        bit_cnt <= bit_cnt + 4'd1;
        tx      <= shreg[0];
        shreg   <= {1'b1, shreg[8:1]};
      end
    end else if (active) begin
      baud_cnt <= baud_cnt + BAUD_W'(1);
    end
  end

endmodule

// File: rtl/acq_uart_framer.sv
// rtl/acq_uart_framer.sv - reads 48-bit groups from the acquisition BRAM and sends them as 8-byte UART frames
module acq_uart_framer
  import acq_uart_pkg::*;
#(
  parameter int         CLKS_PER_BIT  = 234,
  parameter int         RD_HIGH_CYC   = 2,
  parameter int         RD_SETTLE_CYC = 3,
  parameter logic [7:0] HEADER        = HEADER_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        bram_empty,
  input  logic [15:0] data_in_1,
  input  logic [15:0] data_in_2,
  input  logic [15:0] data_in_3,
  output logic        rd_clk,
  output logic        tx,
  output logic        busy,
  output logic [15:0] frame_count
);

  localparam int               CYC_MAX     = (RD_HIGH_CYC > RD_SETTLE_CYC) ? RD_HIGH_CYC : RD_SETTLE_CYC;
  localparam int               CYC_W       = $clog2(CYC_MAX + 1);
  localparam logic [CYC_W-1:0] HI_LAST     = CYC_W'(RD_HIGH_CYC - 1);
  localparam logic [CYC_W-1:0] SETTLE_LAST = CYC_W'(RD_SETTLE_CYC - 1);
  localparam idx_t             IDX_LAST    = idx_t'(FRAME_LEN - 1);

  state_t           state, state_n;
  logic [CYC_W-1:0] cyc_cnt;
  idx_t             idx, idx_next;
  logic [47:0]      payload;
  logic [7:0]       chk;
  logic [7:0]       next_byte;
  logic [7:0]       ser_data;
  logic             ser_start, ser_busy, ser_done;

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk  (clk),
    .rst_n(rst_n),
    .start(ser_start),
    .data (ser_data),
    .tx   (tx),
    .busy (ser_busy),
    .done (ser_done)
  );

  assign idx_next = idx + idx_t'(1);

  always_comb begin
    next_byte = HEADER;
    case (idx_next)
      3'd1:    next_byte = payload[47:40];
      3'd2:    next_byte = payload[39:32];
      3'd3:    next_byte = payload[31:24];
      3'd4:    next_byte = payload[23:16];
      3'd5:    next_byte = payload[15:8];
      3'd6:    next_byte = payload[7:0];
      3'd7:    next_byte = chk;
      default: next_byte = HEADER;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  // The header is launched from CAPTURE so its start bit begins on the very next cycle.
  always_comb begin
    state_n   = state;
    ser_start = 1'b0;
    ser_data  = HEADER;
    case (state)
      ST_IDLE:      if (enable && !bram_empty && !ser_busy) state_n = ST_RD_HI;
      ST_RD_HI:     if (cyc_cnt == HI_LAST) state_n = ST_RD_SETTLE;
      ST_RD_SETTLE: if (cyc_cnt == SETTLE_LAST) state_n = ST_CAPTURE;
      ST_CAPTURE: begin
        ser_start = 1'b1;
        state_n   = ST_SEND;
      end
      ST_SEND: begin
        if (ser_done) begin
          if (idx == IDX_LAST) begin
            state_n = ST_DONE;
          end else begin
            ser_start = 1'b1;
            ser_data  = next_byte;
          end
        end
      end
      ST_DONE:  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt     <= '0;
      idx         <= '0;
      payload     <= '0;
      chk         <= '0;
      busy        <= 1'b0;
      rd_clk      <= 1'b0;
      frame_count <= '0;
    end else begin
      rd_clk <= (state_n == ST_RD_HI);
      if (state_n != state)
        cyc_cnt <= '0;
      else if (state == ST_RD_HI || state == ST_RD_SETTLE)
        cyc_cnt <= cyc_cnt + CYC_W'(1);
      case (state)
        ST_IDLE: if (state_n == ST_RD_HI) busy <= 1'b1;
        ST_CAPTURE: begin
          payload <= {data_in_1, data_in_2, data_in_3};
          chk     <= data_in_1[15:8] ^ data_in_1[7:0] ^ data_in_2[15:8] ^
                     data_in_2[7:0]  ^ data_in_3[15:8] ^ data_in_3[7:0];
          idx     <= '0;
        end
        ST_SEND: begin
          if (ser_done) begin
            if (idx == IDX_LAST) frame_count <= frame_count + 16'd1;
            else                 idx <= idx_next;
          end
        end
        ST_DONE: busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
